// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage MIPS core: PC/pipeline-register
// enables, bubbles and flushes for load-use, taken branches and mult/div occupancy.
module hazard_stall_controller #(
  parameter int REG_ADDR_W  = 5,
  parameter int MULDIV_LAT  = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [REG_ADDR_W-1:0]  id_rs,
  input  logic [REG_ADDR_W-1:0]  id_rt,
  input  logic                   id_uses_rt,
  input  logic                   ex_mem_read,
  input  logic [REG_ADDR_W-1:0]  ex_rt,
  input  logic                   branch_taken,
  input  logic                   muldiv_start,
  output logic                   start_pc,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   ifid_flush,
  output logic                   idex_write,
  output logic                   idex_bubble,
  output logic                   exmem_bubble,
  output logic                   muldiv_busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_MULDIV = 2'd2
  } state_t;

  // The start cycle is itself a stall cycle, so MULDIV only covers LAT-1 cycles.
  localparam logic [7:0]             MD_LOAD   = 8'(MULDIV_LAT - 2);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

  state_t                 state_r;
  state_t                 next_state_s;
  logic [7:0]             cnt_r;
  logic [7:0]             cnt_nxt_s;
  logic [STALL_CNT_W-1:0] stall_cnt_r;
  logic                   load_use_s;

  function automatic logic load_use_f(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] dst,
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rt,
    input logic                  uses_rt
  );
    return mem_read && (dst != {REG_ADDR_W{1'b0}}) &&
           ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

  assign load_use_s   = load_use_f(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);
  assign stall_cycles = stall_cnt_r;

  // State, mult/div down-counter and saturating stall counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= ST_BOOT;
      cnt_r       <= 8'd0;
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_nxt_s;
      if ((state_r != ST_BOOT) && !pc_write && (stall_cnt_r != STALL_MAX)) begin
        stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  // Next-state and pipeline control outputs.
  always_comb begin
    next_state_s = state_r;
    cnt_nxt_s    = cnt_r;
    start_pc     = 1'b1;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    muldiv_busy  = 1'b0;

    case (state_r)
      ST_BOOT: begin
        start_pc     = 1'b0;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        exmem_bubble = 1'b1;
        next_state_s = ST_RUN;
      end
      ST_RUN: begin
        if (muldiv_start) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_bubble = 1'b1;
          next_state_s = ST_MULDIV;
          cnt_nxt_s    = MD_LOAD;
        end else if (branch_taken) begin
          // Flushing the younger instruction makes any load-use stall moot.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (load_use_s) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_MULDIV: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_bubble = 1'b1;
        muldiv_busy  = 1'b1;
        if (cnt_r == 8'd0) begin
          next_state_s = ST_RUN;
        end else begin
          cnt_nxt_s = cnt_r - 8'd1;
        end
      end
      default: begin
        start_pc     = 1'b0;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        exmem_bubble = 1'b1;
        next_state_s = ST_BOOT;
        cnt_nxt_s    = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: a cycle model pushes expected
// outputs per driven cycle, compared at the falling edge against two DUT widths.
module tb_hazard_stall_controller;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, branch_taken, muldiv_start;

  logic        sp0, pw0, iw0, if0, xw0, xb0, eb0, mb0;
  logic        sp1, pw1, iw1, if1, xw1, xb1, eb1, mb1;
  logic [15:0] sc0;
  logic [3:0]  sc1;

  int total = 0;
  int bad   = 0;

  // model state
  bit boot;
  int md_left;
  int raw;

  typedef struct packed {
    logic [7:0]  outs;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_stall_controller #(.REG_ADDR_W(5), .MULDIV_LAT(LAT), .STALL_CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .muldiv_start(muldiv_start), .start_pc(sp0), .pc_write(pw0), .ifid_write(iw0),
    .ifid_flush(if0), .idex_write(xw0), .idex_bubble(xb0), .exmem_bubble(eb0),
    .muldiv_busy(mb0), .stall_cycles(sc0));

  hazard_stall_controller #(.REG_ADDR_W(5), .MULDIV_LAT(LAT), .STALL_CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .branch_taken(branch_taken),
    .muldiv_start(muldiv_start), .start_pc(sp1), .pc_write(pw1), .ifid_write(iw1),
    .ifid_flush(if1), .idex_write(xw1), .idex_bubble(xb1), .exmem_bubble(eb1),
    .muldiv_busy(mb1), .stall_cycles(sc1));

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit order: start_pc pc_write ifid_write ifid_flush idex_write idex_bubble exmem_bubble muldiv_busy
  function automatic logic [7:0] model_outs();
    bit lu;
    lu = ex_mem_read && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    if (boot)              return 8'b0001_0110;
    else if (md_left > 0)  return 8'b1000_0011;
    else if (muldiv_start) return 8'b1000_0010;
    else if (branch_taken) return 8'b1111_1100;
    else if (lu)           return 8'b1000_1100;
    else                   return 8'b1110_1000;
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.outs  = model_outs();
    e.cnt16 = (raw > 65535) ? 16'hFFFF : 16'(raw);
    e.cnt4  = (raw > 15) ? 4'hF : 4'(raw);
    return e;
  endfunction

  task automatic model_step(input logic pcw);
    if (!reset) begin
      boot = 1'b1; md_left = 0; raw = 0;
    end else begin
      if (!boot && !pcw) raw++;
      if (boot) boot = 1'b0;
      else if (md_left > 0) md_left--;
      else if (muldiv_start) md_left = LAT - 1;
    end
  endtask

  task automatic run_cycle();
    exp_t e;
    sb.push_back(model_exp());
    @(negedge clk);
    e = sb.pop_front();
    chk_eq("outs16", {sp0, pw0, iw0, if0, xw0, xb0, eb0, mb0}, 32'(e.outs));
    chk_eq("outs4",  {sp1, pw1, iw1, if1, xw1, xb1, eb1, mb1}, 32'(e.outs));
    chk_eq("stall16", 32'(sc0), 32'(e.cnt16));
    chk_eq("stall4",  32'(sc1), 32'(e.cnt4));
    @(posedge clk);
    model_step(e.outs[6]);
    #1;
  endtask

  task automatic drive(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic mr, input logic [4:0] ert,
                       input logic br, input logic ms);
    reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_mem_read = mr; ex_rt = ert; branch_taken = br; muldiv_start = ms;
    run_cycle();
  endtask

  task automatic idle();
    drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; branch_taken = 1'b0; muldiv_start = 1'b0;
    @(posedge clk); #1;
    boot = 1'b1; md_left = 0; raw = 0;

    // reset held, then one BOOT cycle, then RUN
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle();
    idle();
    chk_eq("boot_stall", 32'(sc0), 32'd0);

    // load-use on rs, then register 0, then rt not used
    drive(1'b1, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    idle();
    chk_eq("lu_stall", 32'(sc0), 32'd1);
    drive(1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 5'd4, 5'd8, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
    drive(1'b1, 5'd4, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
    idle();
    chk_eq("lu_rt_stall", 32'(sc0), 32'd2);

    // branch beats load-use
    drive(1'b1, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
    idle();
    chk_eq("br_stall", 32'(sc0), 32'd2);

    // mult/div with branch pulse mid-stall
    drive(1'b1, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1);
    idle();
    drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle();
    idle();
    chk_eq("md_stall", 32'(sc0), 32'd6);

    // reset in MULDIV cycle 2, then a fresh full mult/div
    drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    drive(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle();
    chk_eq("rst_md_stall", 32'(sc0), 32'd0);
    drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    repeat (3) idle();
    idle();
    chk_eq("md2_stall", 32'(sc0), 32'd4);

    // back-to-back mult/div saturates the narrow counter
    repeat (24) drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle();
    chk_eq("sat16", 32'(sc0), 32'd28);
    chk_eq("sat4", 32'(sc1), 32'd15);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 59) != 0), 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 5)),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. It generates the PC and pipeline-register write-enables, bubbles and flushes for three cases: load-use hazards, taken branches/jumps resolved in EX, and multi-cycle mult/div occupancy of EX. It also holds the pipeline for one boot cycle after reset and keeps a saturating stall-cycle counter for debug.

Parameters:
REG_ADDR_W, 5, register-file address width
MULDIV_LAT, 4, number of stall cycles a mult/div imposes, counted from its start cycle; legal range 2..255
STALL_CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
id_rs  in  REG_ADDR_W  rs field of the instruction in ID
id_rt  in  REG_ADDR_W  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_mem_read  in  1  EX instruction is a load
ex_rt  in  REG_ADDR_W  destination of the EX load
branch_taken  in  1  EX resolved a taken branch or jump
muldiv_start  in  1  EX holds a mult/div in its first EX cycle
start_pc  out  1  PC enabled; low only in BOOT
pc_write  out  1  PC register write enable
ifid_write  out  1  IF/ID write enable
ifid_flush  out  1  clear IF/ID to NOP
idex_write  out  1  ID/EX write enable
idex_bubble  out  1  load NOP into ID/EX
exmem_bubble  out  1  load NOP into EX/MEM
muldiv_busy  out  1  FSM is in MULDIV
stall_cycles  out  STALL_CNT_W  saturating count of cycles with pc_write=0 outside BOOT

Behaviour:
- State register, mult/div counter (cnt, 8 bit) and stall_cycles update on the rising edge of clk. All outputs except stall_cycles are combinational from state and inputs.
- Reset: reset=0 at an edge sets state=BOOT, cnt=0 and stall_cycles=0. This applies in any state, including mid-MULDIV.
- BOOT:
  - start_pc=0, pc_write=0, ifid_write=0, idex_write=0, ifid_flush=1, idex_bubble=1, exmem_bubble=1, muldiv_busy=0.
  - Always moves to RUN on the next edge.
- RUN defaults: start_pc=1, pc_write=1, ifid_write=1, idex_write=1, all flush/bubble outputs 0.
- RUN priority, highest first:
  1. muldiv_start=1:
     - Outputs: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1.
     - Next state MULDIV, cnt<=MULDIV_LAT-2.
     - branch_taken and load-use are ignored this cycle.
  2. branch_taken=1:
     - Outputs: pc_write=1 (target loads), ifid_flush=1, idex_bubble=1.
     - Load-use is ignored, because the stalled instruction is being flushed.
  3. Load-use hazard:
     - Condition: ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)).
     - Outputs: pc_write=0, ifid_write=0, idex_bubble=1, idex_write=1.
     - Lasts exactly one cycle; the hazard clears naturally once the load reaches MEM.
- MULDIV:
  - Outputs: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1, muldiv_busy=1.
  - If cnt==0, next state is RUN; otherwise cnt<=cnt-1.
  - muldiv_start, branch_taken and load-use inputs are ignored.
- Mult/div timing: muldiv_start at cycle t gives stall outputs on cycles t..t+MULDIV_LAT-1, and RUN resumes at t+MULDIV_LAT.
- stall_cycles increments by 1 on every edge where the state is not BOOT and pc_write=0. It holds at 2^STALL_CNT_W-1 and never wraps.
- Register 0 never causes a stall: ex_rt==0 means no hazard.
- Illegal state encodings recover to BOOT on the next edge.

Test Plan:
- Reset held 3 cycles, then released → BOOT for 1 cycle (start_pc=0, pc_write=0, ifid_flush=1); next cycle RUN with start_pc=1, pc_write=1, stall_cycles=0.
- RUN, ex_mem_read=1, ex_rt=8, id_rs=8 → exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1, stall_cycles=1. Repeat with ex_rt=0, id_rs=0 → no stall. Repeat with id_rt=8, id_uses_rt=0 → no stall.
- Load-use condition and branch_taken=1 in the same cycle → ifid_flush=1, idex_bubble=1, pc_write=1, stall_cycles unchanged.
- muldiv_start pulse, MULDIV_LAT=4 → pc_write=0 and exmem_bubble=1 for 4 cycles; muldiv_busy=1 for the last 3; RUN resumes on cycle 5; stall_cycles=4. branch_taken pulsed mid-stall has no effect.
- reset=0 asserted during MULDIV cycle 2 → next edge gives BOOT, muldiv_busy=0, stall_cycles=0; a new muldiv_start after recovery gives a full 4-cycle stall.
- STALL_CNT_W=4, continuous muldiv_start/load-use stalls → stall_cycles reaches 15 and stays at 15.
